// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender (zero/sign/upper/branch) behind a 2-entry valid/ready skid buffer.
// Upper mode is built only when IMM_EXTEND_PIPE_UPPER_EN is defined.
module imm_extend_pipe #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic [4:0]       in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [4:0]       out_tag,
    output logic             bad_mode
);

    localparam int unsigned PAD_W = OUT_W - IN_W;

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_t;

    state_t           state;
    logic [OUT_W-1:0] skid_data;
    logic [4:0]       skid_tag;
    logic [OUT_W-1:0] sx;
    logic [OUT_W-1:0] ext;
    logic             accept;
    logic             drain;

    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    always_comb begin
        sx  = {{PAD_W{in_imm[IN_W-1]}}, in_imm};
        ext = {{PAD_W{1'b0}}, in_imm};
        case (in_mode)
            2'b01:   ext = sx;
            2'b11:   ext = {sx[OUT_W-3:0], 2'b00};
`ifdef IMM_EXTEND_PIPE_UPPER_EN
            2'b10:   ext = {in_imm, {PAD_W{1'b0}}};
`endif
            default: ext = {{PAD_W{1'b0}}, in_imm};
        endcase
    end

    // out_data/out_tag are the head entry; skid_* holds the second entry when full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StEmpty;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= '0;
            skid_data <= '0;
            skid_tag  <= '0;
        end else begin
            case (state)
                StEmpty: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        out_data  <= ext;
                        out_tag   <= in_tag;
                        out_valid <= 1'b1;
                        state     <= StOne;
                    end
                end
                StOne: begin
                    in_ready <= 1'b1;
                    if (accept && !drain) begin
                        skid_data <= ext;
                        skid_tag  <= in_tag;
                        in_ready  <= 1'b0;
                        state     <= StTwo;
                    end else if (drain && !accept) begin
                        out_valid <= 1'b0;
                        state     <= StEmpty;
                    end else if (accept && drain) begin
                        out_data <= ext;
                        out_tag  <= in_tag;
                    end
                end
                StTwo: begin
                    if (drain) begin
                        out_data <= skid_data;
                        out_tag  <= skid_tag;
                        in_ready <= 1'b1;
                        state    <= StOne;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= StEmpty;
                end
            endcase
        end
    end

`ifdef IMM_EXTEND_PIPE_UPPER_EN
    assign bad_mode = 1'b0;
`else
    logic bad_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bad_q <= 1'b0;
        end else if (accept && in_mode == 2'b10) begin
            bad_q <= 1'b1;
        end
    end

    assign bad_mode = bad_q;
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: directed mode checks plus randomized streams scored against
// an arithmetic extension model and a depth-2 FIFO queue model.
module tb_imm_extend_pipe;

    localparam int IN_W  = 16;
    localparam int OUT_W = 32;
`ifdef IMM_EXTEND_PIPE_UPPER_EN
    localparam bit UPPER = 1'b1;
`else
    localparam bit UPPER = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_imm;
    logic [1:0]       in_mode;
    logic [4:0]       in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [4:0]       out_tag;
    logic             bad_mode;

    int n_checks = 0;
    int n_fail   = 0;

    logic [OUT_W-1:0] exp_q[$];
    logic [4:0]       tag_q[$];
    logic [4:0]       drained_tags[$];
    logic             bad_exp;
    int               last_cycles;
    int               n_drained;

    imm_extend_pipe #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .bad_mode  (bad_mode)
    );

    always #5 clk = ~clk;

    // Reference: interpret the immediate as a number, apply the mode arithmetically, keep OUT_W bits.
    function automatic logic [OUT_W-1:0] ref_ext(input logic [IN_W-1:0] imm, input logic [1:0] mode);
        longint u, s, r;
        u = longint'(imm);
        s = imm[IN_W-1] ? u - (64'sd1 <<< IN_W) : u;
        case (mode)
            2'd0:    r = u;
            2'd1:    r = s;
            2'd2:    r = UPPER ? u * (64'sd1 <<< (OUT_W - IN_W)) : u;
            default: r = s * 4;
        endcase
        return r[OUT_W-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_imm = '0; in_mode = '0; in_tag = '0;
        #12;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        n_checks++; if (out_tag !== '0) begin n_fail++; $display("FAIL reset_out_tag: got %h want 0", out_tag); end
        n_checks++; if (bad_mode !== 1'b0) begin n_fail++; $display("FAIL reset_bad_mode: got %b want 0", bad_mode); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL release_in_ready_early: got %b want 0", in_ready); end
        tick();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL release_out_valid: got %b want 0", out_valid); end
        bad_exp = 1'b0;
    endtask

    task automatic test_zero();
        in_valid = 1'b1; in_imm = 16'h8001; in_mode = 2'b00; in_tag = 5'd3;
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL zero_valid: got %b want 1", out_valid); end
        n_checks++; if (out_data !== 32'h0000_8001) begin n_fail++; $display("FAIL zero_data: got %h want 00008001", out_data); end
        n_checks++; if (out_tag !== 5'd3) begin n_fail++; $display("FAIL zero_tag: got %0d want 3", out_tag); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL zero_drained: got %b want 0", out_valid); end
    endtask

    task automatic test_sign_branch();
        logic [IN_W-1:0]  imms[3];
        logic [1:0]       modes[3];
        logic [OUT_W-1:0] exps[3];
        imms  = '{16'hFFFC, 16'hFFFC, 16'h7FFF};
        modes = '{2'b01, 2'b11, 2'b11};
        exps  = '{32'hFFFF_FFFC, 32'hFFFF_FFF0, 32'h0001_FFFC};
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_imm = imms[i]; in_mode = modes[i]; in_tag = 5'(i + 10);
            tick();
            in_valid = 1'b0;
            n_checks++;
            if (out_data !== exps[i] || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL sign_branch_%0d: got %h valid %b want %h", i, out_data, out_valid, exps[i]);
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
    endtask

    task automatic test_upper();
        logic [OUT_W-1:0] want;
        want = UPPER ? 32'h1234_0000 : 32'h0000_1234;
        in_valid = 1'b1; in_imm = 16'h1234; in_mode = 2'b10; in_tag = 5'd7;
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_data !== want) begin n_fail++; $display("FAIL upper_data: got %h want %h", out_data, want); end
        n_checks++; if (bad_mode !== !UPPER) begin n_fail++; $display("FAIL upper_bad_mode: got %b want %b", bad_mode, !UPPER); end
        out_ready = 1'b1;
        in_valid = 1'b1; in_mode = 2'b11;
        for (int i = 0; i < 10; i++) begin
            in_imm = 16'($urandom);
            in_mode = (i % 2 == 0) ? 2'b11 : 2'b01;
            tick();
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        n_checks++; if (bad_mode !== !UPPER) begin n_fail++; $display("FAIL upper_bad_sticky: got %b want %b", bad_mode, !UPPER); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL upper_drained: got %b want 0", out_valid); end
        bad_exp = !UPPER;
    endtask

    // Random stream scored against a depth-2 queue model; checks every cycle.
    task automatic stream(input int n_items, input int pv, input int pr, input int stall, input bit seq_tags);
        int sent = 0;
        int cyc  = 0;
        logic acc, drn;
        logic [OUT_W-1:0] e;
        n_drained = 0;
        drained_tags.delete();
        while ((sent < n_items || exp_q.size() > 0) && cyc < 5000) begin
            n_checks++;
            if (out_valid !== (exp_q.size() > 0)) begin
                n_fail++; $display("FAIL stream_out_valid cyc %0d: got %b want %b", cyc, out_valid, exp_q.size() > 0);
            end
            n_checks++;
            if (in_ready !== (exp_q.size() < 2)) begin
                n_fail++; $display("FAIL stream_in_ready cyc %0d: got %b want %b", cyc, in_ready, exp_q.size() < 2);
            end
            if (exp_q.size() > 0) begin
                n_checks++;
                if (out_data !== exp_q[0] || out_tag !== tag_q[0]) begin
                    n_fail++;
                    $display("FAIL stream_head cyc %0d: got %h/%0d want %h/%0d", cyc, out_data, out_tag, exp_q[0], tag_q[0]);
                end
            end
            n_checks++;
            if (bad_mode !== bad_exp) begin
                n_fail++; $display("FAIL stream_bad_mode cyc %0d: got %b want %b", cyc, bad_mode, bad_exp);
            end
            in_valid  = (sent < n_items) && ($urandom_range(99) < pv);
            in_imm    = 16'($urandom);
            in_mode   = 2'($urandom);
            in_tag    = seq_tags ? 5'(sent + 1) : 5'($urandom);
            out_ready = (cyc >= stall) && ($urandom_range(99) < pr);
            acc = in_valid && (exp_q.size() < 2);
            drn = (exp_q.size() > 0) && out_ready;
            e   = ref_ext(in_imm, in_mode);
            tick();
            cyc++;
            if (drn) begin
                void'(exp_q.pop_front());
                drained_tags.push_back(tag_q.pop_front());
                n_drained++;
            end
            if (acc) begin
                exp_q.push_back(e);
                tag_q.push_back(in_tag);
                sent++;
                if (in_mode == 2'b10 && !UPPER) bad_exp = 1'b1;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        last_cycles = cyc;
        n_checks++;
        if (sent != n_items || exp_q.size() != 0) begin
            n_fail++; $display("FAIL stream_timeout: sent %0d of %0d, %0d left", sent, n_items, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        stream(4, 100, 100, 6, 1'b1);
        n_checks++;
        if (drained_tags.size() != 4) begin
            n_fail++; $display("FAIL bp_count: got %0d want 4", drained_tags.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (drained_tags[i] !== 5'(i + 1)) begin
                    n_fail++; $display("FAIL bp_order %0d: got %0d want %0d", i, drained_tags[i], i + 1);
                end
            end
        end
    endtask

    task automatic test_full_rate();
        stream(100, 100, 100, 0, 1'b0);
        n_checks++;
        if (n_drained != 100 || last_cycles != 101) begin
            n_fail++; $display("FAIL full_rate: drained %0d in %0d cycles want 100 in 101", n_drained, last_cycles);
        end
    endtask

    task automatic test_random_ready();
        stream(200, 70, 50, 0, 1'b0);
        n_checks++;
        if (n_drained != 200) begin
            n_fail++; $display("FAIL random_ready_count: got %0d want 200", n_drained);
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_imm = 16'($urandom); in_mode = 2'b01; in_tag = 5'(20 + i);
            tick();
        end
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL midrst_full: valid %b ready %b want 1 0", out_valid, in_ready);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_in_ready: got %b want 0", in_ready); end
        n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL midrst_out_data: got %h want 0", out_data); end
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        tag_q.delete();
        bad_exp = 1'b0;
        tick();
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL midrst_release: valid %b ready %b want 0 1", out_valid, in_ready);
        end
        stream(20, 80, 80, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_zero();
        test_sign_branch();
        test_upper();
        test_backpressure();
        test_full_rate();
        test_random_ready();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Parametrised, pipelined immediate extender for the datapath. It widens an IN_W-bit immediate field to OUT_W bits in one of four modes: zero, sign, upper, and branch-offset. It replaces single-mode combinational extension in front of the ALU operand mux and the branch-target adder. Input and output use valid/ready handshakes with a 2-entry skid buffer, so a full-rate stream passes with no bubbles and output data is registered.

## Interface
- IN_W, 16, immediate input width; legal range 2..OUT_W-2
- OUT_W, 32, extended output width; must satisfy OUT_W ≥ IN_W+2
- Clk  input  1  rising-edge clock; the block's only clock
- Rst_n  input  1  asynchronous, active-low reset; deassertion synchronised externally
- in_valid  input  1  in_imm/in_mode/in_tag are valid
- in_ready  output  1  block can accept; registered
- in_imm  input  IN_W  raw immediate field
- in_mode  input  2  00 zero, 01 sign, 10 upper, 11 branch
- in_tag  input  5  opaque tag (destination register), passed through unchanged
- out_valid  output  1  out_data/out_tag are valid
- out_ready  input  1  consumer accepts
- out_data  output  OUT_W  extended result
- out_tag  output  5  tag matching out_data
- bad_mode  output  1  sticky flag, set on a disabled-mode request (see Configuration)

## Operation
- Transfer happens on a Clk edge where valid && ready on that side.
- Extension is computed combinationally on accept; only the result and tag are stored.
  - 00 zero: {(OUT_W-IN_W){0}, in_imm}
  - 01 sign: {(OUT_W-IN_W){in_imm[IN_W-1]}, in_imm}
  - 10 upper: {in_imm, (OUT_W-IN_W){0}}; the low field is zero-filled
  - 11 branch: sign-extend to OUT_W, then shift left 2; the top two extended bits are discarded, with no saturation
- Buffer FSM, with occupancy = number of valid stored entries:
  - EMPTY: out_valid=0, in_ready=1
    - accept -> ONE
  - ONE: out_valid=1, in_ready=1
    - accept without drain -> TWO
    - drain without accept -> EMPTY
    - both -> ONE, holding the new entry
  - TWO: out_valid=1, in_ready=0
    - drain -> ONE
    - in_valid is ignored
- Ordering is strict FIFO. out_data and out_tag stay stable while out_valid && !out_ready.
- Entries in EMPTY/free slots hold their last value; they are not zeroed.
- Reset values on Rst_n low, asynchronous:
  - state=EMPTY, out_valid=0, in_ready=0 (forced low while Rst_n is low), out_data=0, out_tag=0, bad_mode=0
- in_ready rises on the first Clk edge after Rst_n deasserts.
- Reset mid-operation discards all buffered entries immediately; no partial output is produced.

## Timing
- Latency: an input accepted at edge N is presented on out_* after edge N and can be consumed at edge N+1 or later.
- Throughput: 1 transfer/cycle sustained when out_ready=1.
- in_ready is a register output and never depends combinationally on out_ready in the same cycle.
- out_ready may toggle arbitrarily.
- Simultaneous accept and drain in ONE keeps the level at ONE with no bubble.
- in_valid may drop without a transfer; there is no retraction rule on the input side.

## Configuration
- Macro: IMM_EXTEND_PIPE_UPPER_EN.
- Defined: mode 10 behaves as specified above, and bad_mode stays 0 permanently.
- Undefined: upper-mode logic is not synthesised.
  - Mode 10 is accepted and produces the zero-extend result.
  - bad_mode is set on the accepting edge and stays set until Rst_n.
  - Modes 00, 01 and 11 are unchanged.

## Test plan
- Reset, then single zero-extend: IN_W=16, OUT_W=32, in_imm=16'h8001, mode 00, tag 5'd3 -> out_data=32'h00008001, out_tag=3, one cycle after accept. Before the first edge after reset: out_valid=0, in_ready=0.
- Sign and branch modes: in_imm=16'hFFFC with mode 01 -> 32'hFFFFFFFC. Same immediate with mode 11 -> 32'hFFFFFFF0. in_imm=16'h7FFF with mode 11 -> 32'h0001FFFC.
- Upper mode: in_imm=16'h1234, mode 10.
  - Macro defined -> 32'h12340000, bad_mode=0.
  - Macro undefined -> 32'h00001234, bad_mode=1 and still 1 after 10 further legal transfers.
- Backpressure: stream 4 items with tags 1..4 while out_ready=0.
  - Buffer fills at 2 and in_ready drops.
  - Release out_ready -> tags 1,2,3,4 emerge in order, with data stable while stalled.
- Full rate: 100 random transfers with in_valid=out_ready=1 -> 100 outputs in 100 consecutive cycles after the first, results match the reference model. Random out_ready toggling also keeps FIFO order.
- Reset mid-stream: assert Rst_n low with 2 entries buffered -> out_valid=0 immediately with no clock edge. After release, no stale entry appears.
